// File: rtl/exe_seq_pkg.sv
// Shared types and widths for the execute-stage sequencer.
package exe_seq_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    typedef enum logic [2:0] {
        DRAIN,
        IDLE,
        SETUP,
        WAIT,
        OUT,
        ERR
    } state_e;

    // Stage results captured on the completion edge.
    typedef struct packed {
        logic [ADDR_W-1:0] target;
        logic              branch;
        logic              regwrite;
    } exe_res_t;

endpackage

// File: rtl/exe_stage_seq_sync.sv
// Multi-flop synchronizer bringing one asynchronous bit into the clk domain.
module sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/exe_stage_seq.sv
// Clocked sequencer driving a self-timed execute stage over a 2-phase req/done
// handshake, with valid/ready ports on both clocked sides and a WAIT timeout.
module exe_stage_seq
    import exe_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TW             = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               exe_req,
    output logic [INSTR_W-1:0] exe_instr,
    input  logic               exe_done,
    input  logic [ADDR_W-1:0]  exe_target,
    input  logic               exe_branch,
    input  logic               exe_regwrite,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_target,
    output logic               out_branch,
    output logic               out_regwrite,
    output logic               busy,
    output logic               timeout_err
);

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    exe_res_t           res_q, res_d;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               done_s;
    logic               hs_done;

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_done_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (exe_done),
        .q    (done_s)
    );

    // 2-phase: the stage has answered every request once the phases match.
    assign hs_done = (done_s == req_q);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        instr_d     = instr_q;
        out_instr_d = out_instr_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        unique case (state_q)
            DRAIN: begin
                if (hs_done) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (in_valid) begin
                    instr_d = in_instr;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                req_d   = ~req_q;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (hs_done) begin
                    res_d.target   = exe_target;
                    res_d.branch   = exe_branch;
                    res_d.regwrite = exe_regwrite;
                    out_instr_d    = instr_q;
                    state_d        = OUT;
                end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = DRAIN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= DRAIN;
            req_q       <= 1'b0;
            instr_q     <= '0;
            out_instr_q <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            instr_q     <= instr_d;
            out_instr_q <= out_instr_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    // A done phase that moved while no request was outstanding shows up here.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == SETUP)) begin
            assert (hs_done)
            else $warning("exe_done toggled with no request outstanding");
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == OUT);
    assign busy         = (state_q != IDLE);
    assign exe_req      = req_q;
    assign exe_instr    = instr_q;
    assign out_instr    = out_instr_q;
    assign out_target   = res_q.target;
    assign out_branch   = res_q.branch;
    assign out_regwrite = res_q.regwrite;
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_exe_stage_seq.sv
// Scoreboard bench for exe_stage_seq with a delayed loopback stage model.
`timescale 1ns/1ps
module tb_exe_stage_seq;

    localparam int unsigned TO = 8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        exe_req;
    logic [31:0] exe_instr;
    logic        exe_done;
    logic [31:0] exe_target;
    logic        exe_branch;
    logic        exe_regwrite;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_target;
    logic        out_branch;
    logic        out_regwrite;
    logic        busy;
    logic        timeout_err;

    exe_stage_seq #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TO),
        .TW            (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .exe_req     (exe_req),
        .exe_instr   (exe_instr),
        .exe_done    (exe_done),
        .exe_target  (exe_target),
        .exe_branch  (exe_branch),
        .exe_regwrite(exe_regwrite),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_target  (out_target),
        .out_branch  (out_branch),
        .out_regwrite(out_regwrite),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stage model: echo req onto done after done_dly, results decoded from the bundle.
    logic        loop_en;
    int unsigned done_dly;
    always @(exe_req) begin
        if (loop_en) exe_done <= #(done_dly) exe_req;
    end
    assign exe_branch   = (exe_instr == 32'hCAFEBABE);
    assign exe_target   = exe_branch ? 32'h0 : 32'hDEAFBEEF;
    assign exe_regwrite = exe_instr[0];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] target;
        logic        branch;
        logic        regwrite;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   accept_cyc = 0;
    int   last_lat = 0;
    int   ov_cnt = 0;
    int   req_tog = 0;
    logic ov_prev = 1'b0;
    logic req_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic exp_t model(input logic [31:0] i);
        exp_t e;
        e.instr    = i;
        e.branch   = (i == 32'hCAFEBABE);
        e.target   = e.branch ? 32'h0 : 32'hDEAFBEEF;
        e.regwrite = i[0];
        return e;
    endfunction

    // Output monitor: latency of each result and scoreboard pop on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && !ov_prev) begin
            ov_cnt++;
            last_lat = cyc - accept_cyc;
        end
        ov_prev = out_valid;
        if (exe_req !== req_prev) req_tog++;
        req_prev = exe_req;
        if (rst_n && out_valid && out_ready) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_instr", out_instr, e.instr);
                chk("out_target", out_target, e.target);
                chk("out_branch", 32'(out_branch), 32'(e.branch));
                chk("out_regwrite", 32'(out_regwrite), 32'(e.regwrite));
            end
        end
    end

    // Called just after a posedge; returns just after the accept edge.
    task automatic send(input logic [31:0] ins);
        int n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        chk("accept", 32'(in_ready), 32'd1);
        if (in_ready) begin
            sb.push_back(model(ins));
            accept_cyc = cyc + 1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int maxc, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req_toggle();
        int n = 0;
        logic prev = exe_req;
        do begin
            @(negedge clk);
            n++;
        end while (exe_req == prev && n < 20);
        chk("req_toggle_seen", 32'(exe_req != prev), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int ov0;
        int tog0;
        int tc;
        int n;
        logic [31:0] snap_instr;
        logic [31:0] snap_target;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b1;
        exe_done  = 1'b0;
        loop_en   = 1'b1;
        done_dly  = 15;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_exe_req", 32'(exe_req), 32'd0);
        chk("rst_exe_instr", exe_instr, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_target", out_target, 32'd0);
        chk("rst_out_flags", 32'({out_branch, out_regwrite}), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Test 1: loopback results; out_valid is high in the 6th cycle after accept
        send(32'hCAFEBABE);
        chk("t1_exe_instr", exe_instr, 32'hCAFEBABE);
        wait_drain(50, "t1_drain_a");
        chk("t1_lat_a", 32'(last_lat), 32'd5);
        send(32'h0000_0001);
        wait_drain(50, "t1_drain_b");
        chk("t1_lat_b", 32'(last_lat), 32'd5);

        // Test 2: three back-to-back instructions with a 5-cycle output stall
        tog0 = req_tog;
        out_ready = 1'b0;
        fork
            begin
                send(32'h0000_0010);
                send(32'hCAFEBABE);
                send(32'h0000_0021);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 50);
                chk("t2_first_valid", 32'(out_valid), 32'd1);
                snap_instr  = out_instr;
                snap_target = out_target;
                repeat (5) begin
                    @(negedge clk);
                    chk("t2_stall_instr", out_instr, snap_instr);
                    chk("t2_stall_target", out_target, snap_target);
                    chk("t2_stall_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain(100, "t2_drain");
        chk("t2_req_toggles", 32'(req_tog - tog0), 32'd3);

        // Test 4: reset one cycle after the request toggle, done still in flight
        ov0 = ov_cnt;
        send(32'h1234_5678);
        wait_req_toggle();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("t4_in_ready", 32'(in_ready), 32'd0);
        chk("t4_exe_req", 32'(exe_req), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        repeat (10) @(negedge clk);
        chk("t4_no_out", 32'(ov_cnt - ov0), 32'd0);
        chk("t4_idle_again", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(32'h0000_0042);
        wait_drain(50, "t4_drain");
        chk("t4_lat", 32'(last_lat), 32'd5);

        // Test 5: done_s matches on the counter's final WAIT cycle
        done_dly = 55;
        send(32'hCAFEBABE);
        wait_drain(60, "t5_drain");
        chk("t5_lat", 32'(last_lat), 32'd9);
        chk("t5_no_timeout", 32'(timeout_err), 32'd0);
        done_dly = 15;

        // Test 6: spurious done toggle in IDLE; next transaction completes at once
        loop_en = 1'b0;
        exe_done = ~exe_done;
        repeat (4) @(negedge clk);
        chk("t6_still_idle", 32'(in_ready), 32'd1);
        chk("t6_no_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(32'h0000_0003);
        wait_drain(20, "t6_drain");
        chk("t6_lat", 32'(last_lat), 32'd2);

        // Test 3: stage never answers
        ov0 = ov_cnt;
        send(32'h0000_0005);
        wait_req_toggle();
        tc = cyc;
        n = 0;
        while (!timeout_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t3_timeout_cycles", 32'(cyc - tc), 32'(TO));
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_out_valid", 32'(out_valid), 32'd0);
        exe_done = ~exe_done;
        repeat (6) @(negedge clk);
        chk("t3_sticky", 32'(timeout_err), 32'd1);
        chk("t3_err_in_ready", 32'(in_ready), 32'd0);
        chk("t3_no_out", 32'(ov_cnt - ov0), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        exe_done = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t3_cleared", 32'(timeout_err), 32'd0);
        loop_en = 1'b1;
        @(posedge clk);
        #1;
        send(32'h0000_0001);
        wait_drain(50, "t3_recover");
        chk("t3_recover_lat", 32'(last_lat), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
